mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store unit; sits upstream of the MEM/WB pipeline register. Decodes the EX/MEM
//  address, drives the data-memory handshake, owns the memory-mapped IO registers, formats load
//  data. Its ld_data and o_io_* outputs feed the MEM/WB register. Stalls the pipeline on DMEM wait states.
// PARAMETERS
//  DMEM_AW      16  byte-address width of DMEM window at 0x0000_0000
//  TIMEOUT_CYC  64  max wait cycles for i_dmem_ack before bus error
//  SW_SYNC      2   synchronizer depth for i_io_sw (>=2)
// PORTS
//  i_clk          in   1   clock; all state on posedge
//  i_rst          in   1   asynchronous, active-high reset
//  i_lsu_vld      in   1   MEM-stage instruction valid
//  i_lsu_rden     in   1   load request
//  i_lsu_wren     in   1   store request
//  i_funct3       in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_lsu_addr     in   32  byte address (ALU result)
//  i_st_data      in   32  store data (rs2)
//  i_io_sw        in   32  raw switches (asynchronous)
//  o_ld_data      out  32  formatted load data (comb.)
//  o_stall        out  1   hold EX/MEM and earlier; MEM/WB takes bubble
//  o_bus_err      out  1   one-cycle pulse on DMEM timeout
//  o_dmem_req     out  1   DMEM request (held until ack)
//  o_dmem_we      out  1   DMEM write
//  o_dmem_addr    out  DMEM_AW  word-aligned byte address
//  o_dmem_wdata   out  32  lane-replicated store data
//  o_dmem_bmask   out  4   byte enables
//  i_dmem_ack     in   1   DMEM done; rdata valid same cycle
//  i_dmem_rdata   in   32  DMEM read word
//  o_io_ledr/o_io_ledg/o_io_lcd out 32 each; o_io_hex0..o_io_hex7 out 7 each
//  o_misaligned   out  1   only with LSU_MISALIGN_TRAP_EN
// BEHAVIOUR
//  - Map: DMEM 0x0000_0000+2^DMEM_AW; LEDR 0x1000_0000; LEDG 0x1000_1000; HEX0-3 0x1000_2000
//    (hexN at bits [8N+6:8N]); HEX4-7 0x1000_3000; LCD 0x1000_4000; SW 0x1001_0000 (read-only).
//  - Access = i_lsu_vld & (rden|wren). rden&wren together -> store; o_ld_data=0.
//  - Reset: all IO regs 0, sync chain 0, FSM IDLE, o_dmem_req/o_stall/o_bus_err/o_misaligned 0.
//  - IO store: byte-masked write at posedge, zero wait. IO/SW load: comb. from register/sync chain.
//  - Unmapped or SW store: ignored; unmapped load returns 0; never stalls.
//  - Lanes: SB bmask=1<<a[1:0], data replicated x4; SH bmask=3<<{a[1],0}; SW 4'hF.
//    Loads extract lane, sign-extend (B/H) or zero-extend (BU/HU). Other funct3 = word.
//  - FSM IDLE/WAIT. o_dmem_req = (IDLE & dmem access) | WAIT; fields comb. from inputs (held by stall).
//    IDLE: req & ack -> stay IDLE (zero-wait); req & ~ack -> WAIT, counter=1.
//    WAIT: ack -> IDLE; counter==TIMEOUT_CYC -> IDLE, o_bus_err pulse, load returns 0; else counter++.
//  - o_stall = o_dmem_req & ~i_dmem_ack & ~timeout; drops in the ack/timeout cycle so MEM/WB
//    captures o_ld_data that edge.
//  - Reset mid-WAIT: async return to IDLE, req drops immediately; IO regs cleared.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with a[0]!=0 or W with a[1:0]!=0 -> o_misaligned=1 (comb.),
//   no DMEM req, no IO write, load returns 0, no stall.
//  Undefined: o_misaligned absent; a[0] (H) / a[1:0] (W) ignored, access forced aligned.
// STRUCTURE
//  lsu_pkg: address-map base/mask constants, funct3 enum, FSM state enum, TIMEOUT counter width.
//  Sub-module lsu_load_align: comb. lane extract + sign/zero extend, shared by IO and DMEM paths.
// TESTING
//  SW 0xDEADBEEF @0x1000_0000 -> o_io_ledr=0xDEADBEEF next edge; LW same addr returns it.
//  SB 0x5A @0x1000_2001 -> o_io_hex1=7'h5A, hex0/2/3 unchanged.
//  LB @0x0000_0003, ack after 3 cycles, rdata 0x80FF_FF00 -> o_stall 3 cycles, o_ld_data=0xFFFF_FF80.
//  LHU @0x0000_0002, same-cycle ack, rdata 0x8001_1234 -> no stall, o_ld_data=0x0000_8001.
//  No ack for TIMEOUT_CYC -> one o_bus_err pulse, o_stall released, o_ld_data=0.
//  i_io_sw 0x0000_00AA -> visible on LW @0x1001_0000 after SW_SYNC edges; i_rst mid-WAIT -> req=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - memory-mapped IO page bases and the page mask used to decode them
//   - funct3 size/sign encodings and the derived access size
//   - FSM state encoding for the DMEM handshake
//   - width helper for the DMEM timeout counter
package lsu_pkg;

  localparam logic [31:0] IO_PAGE_MASK = 32'hFFFF_F000;
  localparam logic [31:0] LEDR_BASE    = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE    = 32'h1000_1000;
  localparam logic [31:0] HEXL_BASE    = 32'h1000_2000;
  localparam logic [31:0] HEXH_BASE    = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE     = 32'h1000_4000;
  localparam logic [31:0] SW_BASE      = 32'h1001_0000;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  // Any encoding that is not a byte or halfword access is treated as a word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Counter must be able to hold the value TIMEOUT_CYC itself.
  function automatic int unsigned to_cnt_w(input int unsigned timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load formatter shared by the IO and DMEM paths.
//   i_word   : 32-bit word read from the selected source
//   i_lane   : byte offset of the access within the word
//   i_funct3 : size/sign encoding
//   o_data   : selected lane, sign- or zero-extended to 32 bits
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  always_comb begin
    byte_sel = i_word[{i_lane, 3'b000} +: 8];
    half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];
    uns      = f3_unsigned(i_funct3);
    case (f3_size(i_funct3))
      SZ_B:    o_data = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    o_data = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
//   Decodes the EX/MEM address into DMEM / IO / switch / unmapped regions,
//   runs the DMEM request/ack handshake with a timeout, owns the IO output
//   registers and the switch synchronizer, and formats load data.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_lsu_vld/i_lsu_rden/i_lsu_wren/i_funct3/i_lsu_addr/i_st_data : MEM-stage request
//   i_io_sw        : asynchronous switch inputs
//   o_ld_data      : formatted load data (combinational)
//   o_stall        : pipeline hold while DMEM is outstanding
//   o_bus_err      : single-cycle pulse when a DMEM access times out
//   o_dmem_*       : DMEM request fields; i_dmem_ack/i_dmem_rdata : DMEM response
//   o_io_ledr/ledg/lcd, o_io_hex0..7 : IO register outputs
// Build option:
//   LSU_MISALIGN_TRAP_EN : adds o_misaligned and suppresses misaligned H/W accesses;
//                          when undefined, low address bits are forced aligned.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_AW     = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int SW_SYNC     = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_lsu_vld,
  input  logic               i_lsu_rden,
  input  logic               i_lsu_wren,
  input  logic [2:0]         i_funct3,
  input  logic [31:0]        i_lsu_addr,
  input  logic [31:0]        i_st_data,
  input  logic [31:0]        i_io_sw,
  output logic [31:0]        o_ld_data,
  output logic               o_stall,
  output logic               o_bus_err,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [31:0]        o_dmem_wdata,
  output logic [3:0]         o_dmem_bmask,
  input  logic               i_dmem_ack,
  input  logic [31:0]        i_dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic               o_misaligned,
`endif
  output logic [31:0]        o_io_ledr,
  output logic [31:0]        o_io_ledg,
  output logic [31:0]        o_io_lcd,
  output logic [6:0]         o_io_hex0,
  output logic [6:0]         o_io_hex1,
  output logic [6:0]         o_io_hex2,
  output logic [6:0]         o_io_hex3,
  output logic [6:0]         o_io_hex4,
  output logic [6:0]         o_io_hex5,
  output logic [6:0]         o_io_hex6,
  output logic [6:0]         o_io_hex7
);

  localparam int              CNT_W   = to_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      ledr_q, ledr_d, ledg_q, ledg_d, hexl_q, hexl_d;
  logic [31:0]      hexh_q, hexh_d, lcd_q, lcd_d;
  logic [31:0]      sw_sync_q [SW_SYNC];

  size_e       size;
  logic [31:0] addr_eff;
  logic        access, is_st, is_ld, mis, io_we;
  logic        hit_dmem, hit_ledr, hit_ledg, hit_hexl, hit_hexh, hit_lcd, hit_sw;
  logic [3:0]  bmask;
  logic [31:0] wdata, io_rword, ld_word, ld_fmt;
  logic        io_hit, ld_ok, dmem_acc, req, timeout;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  // Request decode, alignment handling and lane generation.
  always_comb begin
    size     = f3_size(i_funct3);
    access   = i_lsu_vld & (i_lsu_rden | i_lsu_wren);
    is_st    = access & i_lsu_wren;
    is_ld    = access & i_lsu_rden & ~i_lsu_wren;
    addr_eff = i_lsu_addr;
    mis      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = access & (((size == SZ_H) & i_lsu_addr[0]) |
                    ((size == SZ_W) & (|i_lsu_addr[1:0])));
`else
    if (size == SZ_H)      addr_eff[0]   = 1'b0;
    else if (size == SZ_W) addr_eff[1:0] = 2'b00;
`endif
    hit_dmem = (addr_eff[31:DMEM_AW] == '0);
    hit_ledr = ((addr_eff & IO_PAGE_MASK) == LEDR_BASE);
    hit_ledg = ((addr_eff & IO_PAGE_MASK) == LEDG_BASE);
    hit_hexl = ((addr_eff & IO_PAGE_MASK) == HEXL_BASE);
    hit_hexh = ((addr_eff & IO_PAGE_MASK) == HEXH_BASE);
    hit_lcd  = ((addr_eff & IO_PAGE_MASK) == LCD_BASE);
    hit_sw   = ((addr_eff & IO_PAGE_MASK) == SW_BASE);
    case (size)
      SZ_B: begin
        bmask = 4'b0001 << addr_eff[1:0];
        wdata = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        bmask = addr_eff[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        bmask = 4'hF;
        wdata = i_st_data;
      end
    endcase
  end

  // IO register writes and readback. Switch page is read-only.
  always_comb begin
    io_we  = is_st & ~mis;
    ledr_d = (io_we & hit_ledr) ? byte_merge(ledr_q, wdata, bmask) : ledr_q;
    ledg_d = (io_we & hit_ledg) ? byte_merge(ledg_q, wdata, bmask) : ledg_q;
    hexl_d = (io_we & hit_hexl) ? byte_merge(hexl_q, wdata, bmask) : hexl_q;
    hexh_d = (io_we & hit_hexh) ? byte_merge(hexh_q, wdata, bmask) : hexh_q;
    lcd_d  = (io_we & hit_lcd)  ? byte_merge(lcd_q,  wdata, bmask) : lcd_q;
    io_hit   = 1'b1;
    io_rword = '0;
    if (hit_ledr)      io_rword = ledr_q;
    else if (hit_ledg) io_rword = ledg_q;
    else if (hit_hexl) io_rword = hexl_q;
    else if (hit_hexh) io_rword = hexh_q;
    else if (hit_lcd)  io_rword = lcd_q;
    else if (hit_sw)   io_rword = sw_sync_q[SW_SYNC-1];
    else               io_hit   = 1'b0;
  end

  // DMEM handshake. Request is masked during reset so it drops the moment
  // reset asserts, even if the pipeline still presents a valid access.
  always_comb begin
    dmem_acc = access & hit_dmem & ~mis;
    req      = ~i_rst & (((state_q == ST_IDLE) & dmem_acc) | (state_q == ST_WAIT));
    timeout  = (state_q == ST_WAIT) & ~i_dmem_ack & (cnt_q == CNT_MAX);
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req & ~i_dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        if (i_dmem_ack | timeout) state_d = ST_IDLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
    endcase
  end

  // Load source select; a timed-out DMEM load formats to zero.
  always_comb begin
    ld_word = '0;
    ld_ok   = 1'b0;
    if (is_ld & ~mis) begin
      if (hit_dmem) begin
        ld_word = i_dmem_rdata;
        ld_ok   = req & i_dmem_ack;
      end else if (io_hit) begin
        ld_word = io_rword;
        ld_ok   = 1'b1;
      end
    end
  end

  lsu_load_align u_align (
    .i_word   (ld_word),
    .i_lane   (addr_eff[1:0]),
    .i_funct3 (i_funct3),
    .o_data   (ld_fmt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
      hexl_q  <= '0;
      hexh_q  <= '0;
      lcd_q   <= '0;
      for (int i = 0; i < SW_SYNC; i++) sw_sync_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      hexl_q  <= hexl_d;
      hexh_q  <= hexh_d;
      lcd_q   <= lcd_d;
      sw_sync_q[0] <= i_io_sw;
      for (int i = 1; i < SW_SYNC; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  assign o_ld_data    = ld_ok ? ld_fmt : 32'd0;
  assign o_dmem_req   = req;
  assign o_stall      = req & ~i_dmem_ack & ~timeout;
  assign o_bus_err    = timeout;
  assign o_dmem_we    = i_lsu_wren;
  assign o_dmem_addr  = {addr_eff[DMEM_AW-1:2], 2'b00};
  assign o_dmem_wdata = wdata;
  assign o_dmem_bmask = bmask;
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misaligned = mis;
`endif
  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hexl_q[6:0];
  assign o_io_hex1 = hexl_q[14:8];
  assign o_io_hex2 = hexl_q[22:16];
  assign o_io_hex3 = hexl_q[30:24];
  assign o_io_hex4 = hexh_q[6:0];
  assign o_io_hex5 = hexh_q[14:8];
  assign o_io_hex6 = hexh_q[22:16];
  assign o_io_hex7 = hexh_q[30:24];

endmodule
